// File: rtl/shift_issue.sv
// Issue stage ahead of the 16-bit shifter: picks the shift amount, folds ROR into ROL and queues requests.
// Latency: a push at edge N is visible on out_* from edge N onward when the queue was empty.
// Backpressure: in_ready drops when the queue is full; out_* hold steady while out_valid & !out_ready.
module shift_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [1:0]       in_op,
  input  logic             in_use_imm,
  input  logic [3:0]       in_imm,
  input  logic [15:0]      in_rs,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_shft_rot,
  output logic [3:0]       out_shamt,
  output logic [TAG_W-1:0] out_tag,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  logic [15:0]      mem_data  [DEPTH];
  logic             mem_rot   [DEPTH];
  logic [3:0]       mem_shamt [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic       push;
  logic       pop;
  logic       illegal;
  logic       push_ok;
  logic [3:0] amt;
  logic       enq_rot;
  logic [3:0] enq_shamt;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign illegal   = (in_op == 2'b11);
  assign push_ok   = push & ~illegal;
  assign amt       = in_use_imm ? in_imm : in_rs[3:0];

  // Translate the op into shifter controls; ROR by n equals ROL by (16 - n) mod 16.
  always_comb begin
    enq_rot   = 1'b0;
    enq_shamt = amt;
    case (in_op)
      OP_ROL:  begin enq_rot = 1'b0; enq_shamt = amt;        end
      OP_SLL:  begin enq_rot = 1'b1; enq_shamt = amt;        end
      OP_ROR:  begin enq_rot = 1'b0; enq_shamt = 4'd0 - amt; end
      default: begin enq_rot = 1'b0; enq_shamt = amt;        end
    endcase
  end

  // Entry storage; no reset needed since out_* are ignored while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst && !flush && push_ok) begin
      mem_data[wr_ptr]  <= in_data;
      mem_rot[wr_ptr]   <= enq_rot;
      mem_shamt[wr_ptr] <= enq_shamt;
      mem_tag[wr_ptr]   <= in_tag;
    end
  end

  // Pointer, occupancy and error-pulse state; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      err <= push & illegal;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_data     = mem_data[rd_ptr];
  assign out_shft_rot = mem_rot[rd_ptr];
  assign out_shamt    = mem_shamt[rd_ptr];
  assign out_tag      = mem_tag[rd_ptr];

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic        in_use_imm;
  logic [3:0]  in_imm;
  logic [15:0] in_rs;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_shft_rot;
  logic [3:0]  out_shamt;
  logic [2:0]  out_tag;
  logic        err;

  int total = 0;
  int bad   = 0;

  shift_issue #(.DEPTH(2), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rs(in_rs), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shft_rot(out_shft_rot), .out_shamt(out_shamt), .out_tag(out_tag), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic use_imm, input logic [3:0] imm,
                         input logic [15:0] rs, input logic [15:0] data, input logic [2:0] tag);
    in_valid   = 1'b1;
    in_op      = op;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_rs      = rs;
    in_data    = data;
    in_tag     = tag;
  endtask

  // One-cycle push with the downstream stalled.
  task automatic send(input logic [1:0] op, input logic use_imm, input logic [3:0] imm,
                      input logic [15:0] rs, input logic [15:0] data, input logic [2:0] tag);
    set_req(op, use_imm, imm, rs, data, tag);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [3:0] ror_amt [3];
  logic [3:0] ror_exp [3];

  initial begin
    ror_amt[0] = 4'd0; ror_exp[0] = 4'd0;
    ror_amt[1] = 4'd1; ror_exp[1] = 4'd15;
    ror_amt[2] = 4'd8; ror_exp[2] = 4'd8;

    // Reset held two edges while a ROL request is offered.
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_req(2'b00, 1'b1, 4'd3, 16'h0, 16'h1234, 3'd0);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b1;
    in_valid = 1'b0;

    // ROL 0x8001 by immediate 1.
    send(2'b00, 1'b1, 4'd1, 16'hFFF7, 16'h8001, 3'd1);
    check("rol_valid", 32'(out_valid),    32'd1);
    check("rol_data",  32'(out_data),     32'h8001);
    check("rol_rot",   32'(out_shft_rot), 32'd0);
    check("rol_shamt", 32'(out_shamt),    32'd1);
    drain_one();
    check("rol_drained", 32'(out_valid), 32'd0);

    // ROL with amount from register low bits, immediate ignored.
    send(2'b00, 1'b0, 4'd9, 16'h1234, 16'h0F0F, 3'd3);
    check("rol_rs_shamt", 32'(out_shamt), 32'd4);
    drain_one();

    // ROR by register value 4 becomes ROL by 12.
    send(2'b10, 1'b0, 4'd7, 16'h0004, 16'h00F0, 3'd2);
    check("ror_rs_data",  32'(out_data),     32'h00F0);
    check("ror_rs_rot",   32'(out_shft_rot), 32'd0);
    check("ror_rs_shamt", 32'(out_shamt),    32'd12);
    drain_one();

    // ROR immediate wrap cases.
    for (int i = 0; i < 3; i++) begin
      send(2'b10, 1'b1, ror_amt[i], 16'hFFFF, 16'h5A5A, 3'(i));
      check("ror_imm_shamt", 32'(out_shamt), 32'(ror_exp[i]));
      drain_one();
    end

    // SLL by 15 with tag 5.
    send(2'b01, 1'b1, 4'd15, 16'h0000, 16'h0001, 3'd5);
    check("sll_rot",   32'(out_shft_rot), 32'd1);
    check("sll_shamt", 32'(out_shamt),    32'd15);
    check("sll_tag",   32'(out_tag),      32'd5);
    drain_one();

    // Backpressure: three offered, two accepted.
    set_req(2'b00, 1'b1, 4'd2, 16'h0, 16'h1001, 3'd1);
    tick();
    check("bp_ready_1", 32'(in_ready), 32'd1);
    set_req(2'b01, 1'b1, 4'd3, 16'h0, 16'h1002, 3'd2);
    tick();
    check("bp_ready_2", 32'(in_ready), 32'd0);
    check("bp_head_2",  32'(out_tag),  32'd1);
    set_req(2'b00, 1'b1, 4'd4, 16'h0, 16'h1003, 3'd3);
    tick();
    check("bp_head_tag",  32'(out_tag),   32'd1);
    check("bp_head_data", 32'(out_data),  32'h1001);
    check("bp_head_amt",  32'(out_shamt), 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_pop1_tag",   32'(out_tag),      32'd2);
    check("bp_pop1_rot",   32'(out_shft_rot), 32'd1);
    check("bp_pop1_ready", 32'(in_ready),     32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Streaming: push and pop every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(2'b00, 1'b1, 4'(i), 16'h0, 16'h2000 + 16'(i), 3'(i));
      tick();
      check("stream_tag",   32'(out_tag),   32'(i));
      check("stream_data",  32'(out_data),  32'h2000 + 32'(i));
      check("stream_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_done", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Illegal op with one entry pending.
    send(2'b00, 1'b1, 4'd1, 16'h0, 16'h3333, 3'd6);
    send(2'b11, 1'b1, 4'd1, 16'h0, 16'h4444, 3'd7);
    check("ill_err",   32'(err),       32'd1);
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_tag",   32'(out_tag),   32'd6);
    tick();
    check("ill_err_pulse", 32'(err), 32'd0);
    drain_one();
    check("ill_not_queued", 32'(out_valid), 32'd0);

    // Flush when full, with a request offered.
    send(2'b00, 1'b1, 4'd1, 16'h0, 16'h5001, 3'd1);
    send(2'b00, 1'b1, 4'd1, 16'h0, 16'h5002, 3'd2);
    check("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    set_req(2'b01, 1'b1, 4'd5, 16'h0, 16'h5003, 3'd3);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);

    // Flush with one entry and a concurrent legal push.
    send(2'b00, 1'b1, 4'd1, 16'h0, 16'h6001, 3'd1);
    flush = 1'b1;
    set_req(2'b00, 1'b1, 4'd2, 16'h0, 16'h6004, 3'd4);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_push_dropped", 32'(out_valid), 32'd0);
    tick();
    check("fl_push_still_gone", 32'(out_valid), 32'd0);

    // Flush alongside an illegal push: no error pulse.
    flush = 1'b1;
    set_req(2'b11, 1'b1, 4'd0, 16'h0, 16'h0, 3'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_ill_err", 32'(err), 32'd0);

    // Reset mid-stream with two entries pending and a push offered.
    send(2'b00, 1'b1, 4'd1, 16'h0, 16'h7001, 3'd1);
    send(2'b00, 1'b1, 4'd1, 16'h0, 16'h7002, 3'd2);
    rst = 1'b0;
    set_req(2'b11, 1'b1, 4'd0, 16'h0, 16'h0, 3'd0);
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_err",   32'(err),       32'd0);

    // Queue still works after reset.
    send(2'b10, 1'b1, 4'd3, 16'h0, 16'hBEEF, 3'd4);
    check("post_rst_shamt", 32'(out_shamt), 32'd13);
    check("post_rst_tag",   32'(out_tag),   32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
Name: shift_issue

Overview:
- Issue-side stage directly upstream of the 16-bit left shifter/rotator in the execute path.
- Accepts decoded shift requests over a valid/ready handshake and selects the shift amount (immediate or register).
- Translates rotate-right into the equivalent left rotate, buffers requests in a small FIFO, and presents operand, Shft_Rot and ShAmt to the shifter with a downstream valid/ready handshake.

Parameters:
DEPTH, 2, number of FIFO entries; power of two, minimum 2.
TAG_W, 3, width of the instruction tag carried alongside each request.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
flush  input  1  synchronous pipeline flush; discards all buffered requests
in_valid  input  1  upstream request valid
in_ready  output  1  stage can accept a request this cycle
in_data  input  16  operand to be shifted
in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 illegal
in_use_imm  input  1  1: amount from in_imm; 0: amount from in_rs[3:0]
in_imm  input  4  immediate shift amount
in_rs  input  16  register operand; only bits [3:0] used
in_tag  input  TAG_W  instruction tag
out_valid  output  1  head entry valid
out_ready  input  1  downstream shifter/EX latch accepts head
out_data  output  16  operand for shifter In
out_shft_rot  output  1  shifter Shft_Rot: 1 = logical shift left, 0 = rotate left
out_shamt  output  4  shifter ShAmt
out_tag  output  TAG_W  tag of head entry
err  output  1  one-cycle pulse: an illegal op was accepted

Behaviour:
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH). Combinational from count only; no dependency on out_ready, so there is no same-cycle pass-through when full.
- Amount selection: amt = in_use_imm ? in_imm : in_rs[3:0].
- Translation at enqueue:
  - ROL: shft_rot = 0, shamt = amt.
  - SLL: shft_rot = 1, shamt = amt.
  - ROR: shft_rot = 0, shamt = (16 - amt) mod 16, 4-bit wrap (amt 0 -> 0, amt 1 -> 15, amt 8 -> 8).
  - Op 11: not enqueued, count unchanged; err = 1 on the following cycle for exactly one cycle. in_ready behaves normally, so the request is consumed.
- Entry stores {data, shft_rot, shamt, tag}.
- Storage: registered circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Outputs:
  - out_valid = (count != 0).
  - out_data / out_shft_rot / out_shamt / out_tag are driven from the entry at the read pointer.
  - Outputs are held stable while out_valid & !out_ready.
- Latency: a request pushed at edge N is visible at out_valid from edge N onward (one cycle), provided the FIFO was empty.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance, order preserved.
- Empty: pop impossible (out_valid = 0); push alone → count 1.
- Full: push impossible; pop alone → count DEPTH-1, and in_ready rises the next cycle.
- Flush (when rst = 1):
  - On the edge, count and both pointers go to 0 and err goes to 0.
  - A concurrent push, legal or illegal, is dropped; a concurrent pop has no extra effect.
  - out_valid = 0 the next cycle.
- Reset (rst = 0 on an edge):
  - count = 0, pointers = 0, err = 0, out_valid = 0, in_ready = 1 after the edge.
  - Takes priority over flush and push/pop, including mid-stream with entries pending.
  - Storage contents need not be cleared; out_data/out_shft_rot/out_shamt/out_tag are don't-care while out_valid = 0.
- err is independent of FIFO state; it still pulses if an illegal op is accepted while entries are pending.

Test Plan:
- Reset: hold rst = 0 two edges with in_valid = 1, op ROL → out_valid = 0, in_ready = 1, err = 0. Release; push ROL data 0x8001 imm 1 → next cycle out_data = 0x8001, out_shft_rot = 0, out_shamt = 1.
- ROR translation: push ROR data 0x00F0, use_imm = 0, rs = 0x0004 → out_shft_rot = 0, out_shamt = 12. Push ROR amt 0 → out_shamt = 0.
- SLL: push SLL with in_imm = 15, tag 5 → out_shft_rot = 1, out_shamt = 15, out_tag = 5.
- Backpressure: out_ready = 0; push 3 requests (DEPTH = 2) → only 2 accepted, and in_ready = 0 after the second. Head fields stay stable. Raise out_ready → tags drain in order, in_ready = 1 one cycle after the first pop.
- Streaming: in_valid = out_ready = 1 for 8 cycles with tags 0..7 → count stays 1, one output per cycle, tags in order, no drops.
- Illegal op and flush:
  - Push op 11 → err = 1 for exactly one cycle, out_valid unaffected.
  - With 2 entries buffered, assert flush together with a push → next cycle out_valid = 0 and count = 0; the flushed push never appears.
